mem_bus_arbiter2: RTL

Two-master arbiter that shares one native memory bus slave port (valid/ready/addr/wdata/wstrb/rdata) between the picorv32 core (master 0) and a second master such as a UART loader or DMA (master 1). It sits between the masters and the address decode that drives the SRAM and UART slaves. It grants one master at a time and holds the grant until the transaction completes. A watchdog terminates transactions the slave never acknowledges.

---
 rtl/mem_bus_arbiter2_pkg.sv | 26 ++
 rtl/mem_bus_arbiter2_watchdog.sv | 46 ++++
 rtl/mem_bus_arbiter2.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter2_pkg
// Function : shared state codes, grant codes and defaults for the bus arbiter
// Revision : 1.0
// ============================================================================
package mem_bus_arbiter2_pkg;

    localparam logic [1:0]  c_st_idle           = 2'd0;
    localparam logic [1:0]  c_st_gnt0           = 2'd1;
    localparam logic [1:0]  c_st_gnt1           = 2'd2;

    localparam logic [1:0]  c_grant_none        = 2'b00;
    localparam logic [1:0]  c_grant_m0          = 2'b01;
    localparam logic [1:0]  c_grant_m1          = 2'b10;

    localparam int          c_timeout_default   = 1024;
    localparam logic [31:0] c_err_rdata_default = 32'hDEAD_BEEF;

    // Counter must hold TIMEOUT itself so it can saturate there.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter2_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : bus_watchdog
// Function : saturating wait counter that flags the last allowed slave cycle
// Revision : 1.0
// ============================================================================
module bus_watchdog
    import mem_bus_arbiter2_pkg::*;
#(
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = ^{clk, rst, run, clear};
            assign expire   = 1'b0;
        end else begin : g_enabled
            localparam int            c_w    = timer_width(TIMEOUT);
            localparam logic [c_w-1:0] c_last = c_w'(TIMEOUT - 1);
            localparam logic [c_w-1:0] c_max  = c_w'(TIMEOUT);

            logic [c_w-1:0] r_timer;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_timer <= '0;
                end else if (clear) begin
                    r_timer <= '0;
                end else if (run && (r_timer != c_max)) begin
                    r_timer <= r_timer + c_w'(1);
                end
            end

            assign expire = run && (r_timer == c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter2
// Function : two-master native memory bus arbiter with slave-response watchdog
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter2
    import mem_bus_arbiter2_pkg::*;
#(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int          TIMEOUT     = c_timeout_default,
    parameter logic [31:0] ERR_RDATA   = c_err_rdata_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_last_grant;   // 1 = master 1 finished last
    logic       w_own_valid;
    logic       w_run;
    logic       w_clear;
    logic       w_expire;
    logic       w_done;

    always_comb begin
        case (r_state)
            c_st_gnt0: w_own_valid = m0_valid;
            c_st_gnt1: w_own_valid = m1_valid;
            default:   w_own_valid = 1'b0;
        endcase
    end

    // Owner still requesting: either the slave answers or the watchdog fires.
    assign w_run   = w_own_valid & ~s_ready;
    assign w_done  = w_own_valid & (s_ready | w_expire);
    assign w_clear = (w_state_next == c_st_idle);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .run    (w_run),
        .clear  (w_clear),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_done) begin
                r_last_grant <= (r_state == c_st_gnt1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (m0_valid && m1_valid) begin
                    w_state_next = (ROUND_ROBIN && !r_last_grant) ? c_st_gnt1 : c_st_gnt0;
                end else if (m0_valid) begin
                    w_state_next = c_st_gnt0;
                end else if (m1_valid) begin
                    w_state_next = c_st_gnt1;
                end
            end
            c_st_gnt0, c_st_gnt1: begin
                // A withdrawn request also lands here, without a ready.
                if (!w_own_valid || w_done) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        grant       = c_grant_none;
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_rdata    = '0;
        timeout_err = w_expire;
        case (r_state)
            c_st_gnt0: begin
                grant    = c_grant_m0;
                s_valid  = m0_valid & ~w_expire;
                s_instr  = m0_instr;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = w_done;
                m0_rdata = w_expire ? ERR_RDATA : s_rdata;
            end
            c_st_gnt1: begin
                grant    = c_grant_m1;
                s_valid  = m1_valid & ~w_expire;
                s_instr  = m1_instr;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = w_done;
                m1_rdata = w_expire ? ERR_RDATA : s_rdata;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
